i2c_calc_target: RTL and testbench
==================================

Name: i2c_calc_target

Overview:
- I2C target (slave) with a byte-addressed register file and a built-in arithmetic/logic unit.
- SCL/SDA are oversampled on the system clock; SDA is driven open-drain.
- Parametrised generation of the team's I2C calculator peripheral:
  - configurable target address;
  - configurable operand width in bytes;
  - configurable synchroniser depth;
  - adds auto-increment register pointer, repeated-START support and a status register.
- Sits behind the tile's bidirectional pins (SDA/SCL on uio).

Parameters:
I2C_ADDR, 7'h2A, 7-bit target address
OP_BYTES, 1, operand width in bytes (1..4); N = OP_BYTES
SYNC_STAGES, 2, synchroniser flops on scl_i/sda_i (>=2)

Ports:
clk  input  1  system clock, >=8x SCL rate
RST  input  1  synchronous active-high reset
scl_i  input  1  raw SCL pin
sda_i  input  1  raw SDA pin
sda_oe  output  1  1 = pull SDA low; 0 = release
result  output  16*N  current RESULT register, mirrored
done  output  1  STATUS[0]
busy  output  1  high while addressed, from address-ACK until STOP, repeated START or NACK

Behaviour:
- Reset: one clk with RST=1 forces:
  - all registers = 0, pointer = 0;
  - sda_oe=0, done=0, busy=0;
  - FSM=IDLE, sync chain set to 1.
- RST mid-transfer releases SDA on the next edge. The bus is ignored until the next START.
- Edge detection on synchronised signals:
  - START = SDA 1->0 while SCL=1;
  - STOP = SDA 0->1 while SCL=1;
  - data bit sampled on SCL rise;
  - sda_oe updated 1 clk after a detected SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK.
  - START from any state -> ADDR, bit counter = 0.
  - STOP from any state -> IDLE.
  - ADDR: shift 8 bits MSB first.
    - addr == I2C_ADDR -> ADDR_ACK: drive ACK (sda_oe=1) for the 9th SCL period.
    - mismatch -> IDLE, no ACK.
    - After ACK: R/W=0 -> PTR; R/W=1 -> RDATA, with the first byte loaded from reg[pointer].
  - PTR: byte -> pointer, ACK, -> WDATA.
    - Pointer >= 4N+2 is taken modulo 4N+2.
  - WDATA: byte -> reg[pointer], ACK, pointer++, stay in WDATA.
  - RDATA: shift reg[pointer] MSB first.
    - sda_oe = ~bit.
    - Release SDA for the 9th clock.
  - RDATA_MACK: master ACK (SDA=0) -> pointer++, load next byte, -> RDATA. Master NACK -> IDLE.
- Pointer wrap: 4N+1 -> 0, for both reads and writes.
- Register map, multi-byte values little-endian:
  - A at 0..N-1;
  - B at N..2N-1;
  - OP at 2N;
  - RESULT at 2N+1..4N (2N bytes);
  - STATUS at 4N+1.
- Writes to RESULT/STATUS are ACKed and discarded.
- STATUS bit assignments:
  - [0] done;
  - [1] carry/borrow;
  - [2] invalid op;
  - [7:3] = 0.
- done clears on any write to A or B.
- Compute trigger: a write to OP computes in the following clk (1-cycle latency). RESULT, STATUS and done update in that clk.
- OP codes (operands zero-extended to 16N bits):
  - 0 ADD: carry = bit 8N of the sum;
  - 1 SUB: A-B, two's complement in 16N bits, borrow = (A<B);
  - 2 MUL: full 16N-bit product;
  - 3 AND, 4 OR, 5 XOR.
  - Other values: RESULT = 0, invalid = 1.
- Read-data snapshot: a byte is captured at its load point. A compute in the middle of a byte does not alter the bits being shifted.
- SDA glitch while SCL=1 that is not a valid START/STOP pattern: not possible after synchronisation; no filtering required.

Test Plan:
- Write 0x54, 0x00, 0xC8, 0x64, 0x00, STOP -> every byte ACKed. Then read via 0x54, 0x03, repeated START, 0x55, reading 3 bytes -> expect 0x2C, 0x01, 0x03 (done|carry).
- A=0xFF, B=0xFF, OP=2 -> result=0xFE01, done=1 one clk after the OP-byte ACK SCL rise.
- Address 0x60 (0x30, write) -> SDA never driven low, busy=0, registers unchanged.
- Pointer 0x05, read 3 bytes with master ACK, then NACK -> bytes from reg5, reg0, reg1 (wrap). FSM returns to IDLE.
- A=0x10, B=0x20, OP=1 -> RESULT=0xFFF0, STATUS=0x03. Then OP=9 -> RESULT=0, STATUS=0x05.
- Assert RST during the 4th bit of a read byte -> sda_oe=0 next clk, registers = 0. Next transaction is addressed correctly.

Source files
------------

// File: rtl/i2c_calc_target.sv
// i2c_calc_target
// I2C target with a small byte-addressed register file and an ALU.
// SCL/SDA are oversampled on clk through a synchroniser; SDA is open-drain.
// Register map (N = OP_BYTES, multi-byte values little-endian):
//   A 0..N-1, B N..2N-1, OP 2N, RESULT 2N+1..4N, STATUS 4N+1
//   STATUS = {5'b0, invalid, carry/borrow, done}
// Ports:
//   clk     system clock, at least 8x the SCL rate
//   RST     synchronous active-high reset
//   scl_i   raw SCL pin
//   sda_i   raw SDA pin
//   sda_oe  1 = pull SDA low, 0 = release
//   result  RESULT register (16*N bits)
//   done    STATUS[0]
//   busy    high from address-ACK until STOP, repeated START or master NACK
module i2c_calc_target #(
  parameter logic [6:0] I2C_ADDR    = 7'h2A,
  parameter int         OP_BYTES    = 1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   sda_oe,
  output logic [16*OP_BYTES-1:0] result,
  output logic                   done,
  output logic                   busy
);

  localparam int         N      = OP_BYTES;
  localparam int         NREG   = 4 * N + 2;
  localparam int         IW     = $clog2(8 * NREG);
  localparam logic [7:0] NREG_B = 8'(NREG);
  localparam logic [7:0] LAST_B = 8'(NREG - 1);
  localparam logic [7:0] OP_IDX = 8'(2 * N);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_MACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic                   scl_prev_r, sda_prev_r;
  logic                   scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_n;
  logic [3:0] cnt_r, cnt_n;
  logic       ack_seen_r, ack_seen_n;
  logic       sda_oe_r, oe_n;
  logic [7:0] shreg_r, shreg_n, tx_r, tx_n;
  logic       rw_r, rw_n;
  logic       busy_r;
  logic       ptr_set_s, wr_en_s, ptr_inc_s;

  logic [7:0]        ptr_r, ptr_next_s;
  logic [8*N-1:0]    a_r, b_r;
  logic [7:0]        op_r;
  logic [16*N-1:0]   result_r, res_s, ax_s, bx_s;
  logic              done_r, carry_r, inv_r, carry_s, inv_s, calc_pend_r;
  logic [7:0]        status_s, byte_in_s, rd_byte_s;
  logic [8*NREG-1:0] regs_flat_s;
  logic [IW-1:0]     rd_idx_s;

  assign scl_s      = scl_sync_r[SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // START/STOP need SCL high on both samples so an SDA change at an SCL edge is ignored
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  assign byte_in_s   = {shreg_r[6:0], sda_s};
  assign ptr_next_s  = (ptr_r == LAST_B) ? 8'd0 : ptr_r + 8'd1;
  assign status_s    = {5'b00000, inv_r, carry_r, done_r};
  assign regs_flat_s = {status_s, result_r, op_r, b_r, a_r};
  assign rd_idx_s    = IW'({ptr_r, 3'b000});
  assign rd_byte_s   = regs_flat_s[rd_idx_s +: 8];

  assign sda_oe = sda_oe_r;
  assign result = result_r;
  assign done   = done_r;
  assign busy   = busy_r;

  // Pin synchroniser plus one-sample history for edge detection
  always_ff @(posedge clk) begin
    if (RST) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // Protocol FSM state and bit-level registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      ack_seen_r <= 1'b0;
      sda_oe_r   <= 1'b0;
      shreg_r    <= 8'd0;
      tx_r       <= 8'd0;
      rw_r       <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      ack_seen_r <= ack_seen_n;
      sda_oe_r   <= oe_n;
      shreg_r    <= shreg_n;
      tx_r       <= tx_n;
      rw_r       <= rw_n;
      busy_r     <= (state_n != IDLE) && (state_n != ADDR);
    end
  end

  // Next-state logic; ACK states drive SDA on the first SCL fall and leave on the second
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    ack_seen_n = ack_seen_r;
    oe_n       = sda_oe_r;
    shreg_n    = shreg_r;
    tx_n       = tx_r;
    rw_n       = rw_r;
    ptr_set_s  = 1'b0;
    wr_en_s    = 1'b0;
    ptr_inc_s  = 1'b0;
    if (start_s) begin
      state_n    = ADDR;
      cnt_n      = 4'd0;
      ack_seen_n = 1'b0;
      oe_n       = 1'b0;
    end else if (stop_s) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else begin
      case (state_r)
        IDLE: state_n = IDLE;
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shreg_n = byte_in_s;
            if (cnt_r == 4'd7) begin
              cnt_n      = 4'd0;
              ack_seen_n = 1'b0;
              case (state_r)
                ADDR: begin
                  if (byte_in_s[7:1] == I2C_ADDR) begin
                    state_n = ADDR_ACK;
                    rw_n    = byte_in_s[0];
                  end else begin
                    state_n = IDLE;
                  end
                end
                PTR:     state_n = PTR_ACK;
                default: state_n = WDATA_ACK;
              endcase
            end else begin
              cnt_n = cnt_r + 4'd1;
            end
          end else begin
            shreg_n = shreg_r;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall_s) begin
            if (ack_seen_r) begin
              ack_seen_n = 1'b0;
              cnt_n      = 4'd0;
              case (state_r)
                ADDR_ACK: begin
                  if (rw_r) begin
                    state_n = RDATA;
                    tx_n    = rd_byte_s;
                    oe_n    = ~rd_byte_s[7];
                  end else begin
                    state_n = PTR;
                    oe_n    = 1'b0;
                  end
                end
                default: begin
                  state_n = WDATA;
                  oe_n    = 1'b0;
                end
              endcase
            end else begin
              oe_n = 1'b1;
            end
          end else if (scl_rise_s) begin
            // Register side effects commit on the ACK-bit SCL rise
            ack_seen_n = 1'b1;
            if (state_r == PTR_ACK) begin
              ptr_set_s = 1'b1;
            end else if (state_r == WDATA_ACK) begin
              wr_en_s = 1'b1;
            end else begin
              ptr_set_s = 1'b0;
            end
          end else begin
            ack_seen_n = ack_seen_r;
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            cnt_n = cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (cnt_r == 4'd8) begin
              state_n    = RDATA_MACK;
              oe_n       = 1'b0;
              cnt_n      = 4'd0;
              ack_seen_n = 1'b0;
            end else begin
              tx_n = {tx_r[6:0], 1'b0};
              oe_n = ~tx_r[6];
            end
          end else begin
            cnt_n = cnt_r;
          end
        end
        RDATA_MACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              state_n = IDLE;
            end else begin
              ack_seen_n = 1'b1;
              ptr_inc_s  = 1'b1;
            end
          end else if (scl_fall_s) begin
            if (ack_seen_r) begin
              state_n    = RDATA;
              tx_n       = rd_byte_s;
              oe_n       = ~rd_byte_s[7];
              cnt_n      = 4'd0;
              ack_seen_n = 1'b0;
            end else begin
              oe_n = 1'b0;
            end
          end else begin
            ack_seen_n = ack_seen_r;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // ALU on zero-extended operands
  always_comb begin
    ax_s    = {{(8*N){1'b0}}, a_r};
    bx_s    = {{(8*N){1'b0}}, b_r};
    res_s   = {(16*N){1'b0}};
    carry_s = 1'b0;
    inv_s   = 1'b0;
    case (op_r)
      8'd0: begin
        res_s   = ax_s + bx_s;
        carry_s = res_s[8*N];
      end
      8'd1: begin
        res_s   = ax_s - bx_s;
        carry_s = (a_r < b_r);
      end
      8'd2:    res_s = ax_s * bx_s;
      8'd3:    res_s = ax_s & bx_s;
      8'd4:    res_s = ax_s | bx_s;
      8'd5:    res_s = ax_s ^ bx_s;
      default: inv_s = 1'b1;
    endcase
  end

  // Register file, pointer and compute-on-OP-write
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_r       <= 8'd0;
      a_r         <= {(8*N){1'b0}};
      b_r         <= {(8*N){1'b0}};
      op_r        <= 8'd0;
      result_r    <= {(16*N){1'b0}};
      done_r      <= 1'b0;
      carry_r     <= 1'b0;
      inv_r       <= 1'b0;
      calc_pend_r <= 1'b0;
    end else begin
      calc_pend_r <= 1'b0;
      if (ptr_set_s) begin
        ptr_r <= shreg_r % NREG_B;
      end else if (wr_en_s || ptr_inc_s) begin
        ptr_r <= ptr_next_s;
      end
      if (wr_en_s) begin
        for (int i = 0; i < N; i++) begin
          if (ptr_r == 8'(i)) begin
            a_r[8*i +: 8] <= shreg_r;
            done_r        <= 1'b0;
          end
          if (ptr_r == 8'(N + i)) begin
            b_r[8*i +: 8] <= shreg_r;
            done_r        <= 1'b0;
          end
        end
        if (ptr_r == OP_IDX) begin
          op_r        <= shreg_r;
          calc_pend_r <= 1'b1;
        end
      end
      if (calc_pend_r) begin
        result_r <= res_s;
        carry_r  <= carry_s;
        inv_r    <= inv_s;
        done_r   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_calc_target.sv
// Directed bench for i2c_calc_target (default parameters: address 0x2A, N=1).
// The bench acts as bus master; SDA is modelled as a wired-AND of master and DUT.
module tb_i2c_calc_target;

  localparam int Q = 20;

  logic        clk = 1'b0;
  logic        RST;
  logic        scl_m, sda_m;
  logic        sda_bus;
  logic        sda_oe, done, busy;
  logic [15:0] result;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          oe_cnt       = 0;
  int          oe_mark;
  logic        ack;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_calc_target dut (
    .clk    (clk),
    .RST    (RST),
    .scl_i  (scl_m),
    .sda_i  (sda_bus),
    .sda_oe (sda_oe),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Count clocks during which the target pulls SDA low
  always @(negedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b0; hold(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; hold(Q);
      scl_m = 1'b1; hold(Q);
      scl_m = 1'b0;
    end
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q/2);
    a = ~sda_bus; hold(Q/2);
    scl_m = 1'b0;
  endtask

  task automatic wr(input logic [7:0] b, input string tag);
    logic a;
    write_byte(b, a);
    check_eq(tag, a, 1'b1);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; hold(Q);
      scl_m = 1'b1; hold(Q/2);
      b[i] = sda_bus; hold(Q/2);
      scl_m = 1'b0;
    end
    sda_m = ~mack; hold(Q);
    scl_m = 1'b1; hold(Q);
    scl_m = 1'b0;
  endtask

  task automatic rd(input logic mack, input logic [7:0] exp, input string tag);
    logic [7:0] b;
    read_byte(mack, b);
    check_eq(tag, b, exp);
  endtask

  initial begin
    RST = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    hold(3);
    RST = 1'b0;
    hold(2);
    check_eq("rst_oe", sda_oe, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_result", result, 16'h0000);

    // ADD 200 + 100
    i2c_start();
    wr(8'h54, "add_addr_ack");
    check_eq("busy_addressed", busy, 1'b1);
    wr(8'h00, "add_ptr_ack");
    wr(8'hC8, "add_a_ack");
    wr(8'h64, "add_b_ack");
    wr(8'h00, "add_op_ack");
    i2c_stop();
    check_eq("busy_after_stop", busy, 1'b0);
    check_eq("add_result", result, 16'h012C);
    check_eq("add_done", done, 1'b1);

    // Read RESULT/STATUS back through a repeated START
    i2c_start();
    wr(8'h54, "rd1_addr_ack");
    wr(8'h03, "rd1_ptr_ack");
    i2c_start();
    wr(8'h55, "rd1_raddr_ack");
    rd(1'b1, 8'h2C, "rd1_res_lo");
    rd(1'b1, 8'h01, "rd1_res_hi");
    rd(1'b0, 8'h03, "rd1_status");
    i2c_stop();

    // MUL 0xFF * 0xFF; done clears on operand write
    i2c_start();
    wr(8'h54, "mul_addr_ack");
    wr(8'h00, "mul_ptr_ack");
    wr(8'hFF, "mul_a_ack");
    wr(8'hFF, "mul_b_ack");
    check_eq("done_cleared", done, 1'b0);
    wr(8'h02, "mul_op_ack");
    check_eq("mul_done", done, 1'b1);
    i2c_stop();
    check_eq("mul_result", result, 16'hFE01);

    // Foreign address is ignored
    oe_mark = oe_cnt;
    i2c_start();
    write_byte(8'h60, ack);
    check_eq("bad_addr_nack", ack, 1'b0);
    check_eq("bad_addr_busy", busy, 1'b0);
    write_byte(8'h00, ack);
    i2c_stop();
    check_eq("bad_addr_no_drive", oe_cnt, oe_mark);
    check_eq("bad_addr_result", result, 16'hFE01);

    // Pointer wrap on read: reg5, reg0, reg1, then NACK
    i2c_start();
    wr(8'h54, "wrap_addr_ack");
    wr(8'h05, "wrap_ptr_ack");
    i2c_start();
    wr(8'h55, "wrap_raddr_ack");
    rd(1'b1, 8'h01, "wrap_status");
    rd(1'b1, 8'hFF, "wrap_reg0");
    rd(1'b0, 8'hFF, "wrap_reg1");
    check_eq("nack_idle_busy", busy, 1'b0);
    i2c_stop();

    // SUB with borrow
    i2c_start();
    wr(8'h54, "sub_addr_ack");
    wr(8'h00, "sub_ptr_ack");
    wr(8'h10, "sub_a_ack");
    wr(8'h20, "sub_b_ack");
    wr(8'h01, "sub_op_ack");
    i2c_stop();
    check_eq("sub_result", result, 16'hFFF0);
    i2c_start();
    wr(8'h54, "sub_st_addr_ack");
    wr(8'h05, "sub_st_ptr_ack");
    i2c_start();
    wr(8'h55, "sub_st_raddr_ack");
    rd(1'b0, 8'h03, "sub_status");
    i2c_stop();

    // Pointer beyond the map is taken modulo 6: 7 -> B
    i2c_start();
    wr(8'h54, "mod_addr_ack");
    wr(8'h07, "mod_ptr_ack");
    i2c_start();
    wr(8'h55, "mod_raddr_ack");
    rd(1'b0, 8'h20, "mod_reg1");
    i2c_stop();

    // Invalid op code
    i2c_start();
    wr(8'h54, "inv_addr_ack");
    wr(8'h02, "inv_ptr_ack");
    wr(8'h09, "inv_op_ack");
    i2c_stop();
    check_eq("inv_result", result, 16'h0000);
    check_eq("inv_done", done, 1'b1);
    i2c_start();
    wr(8'h54, "inv_st_addr_ack");
    wr(8'h05, "inv_st_ptr_ack");
    i2c_start();
    wr(8'h55, "inv_st_raddr_ack");
    rd(1'b0, 8'h05, "inv_status");
    i2c_stop();

    // Reset during the 4th bit of a read byte (A = 0xC8, bit4 = 0 so SDA is pulled low)
    i2c_start();
    wr(8'h54, "rr_addr_ack");
    wr(8'h00, "rr_ptr_ack");
    wr(8'hC8, "rr_a_ack");
    i2c_stop();
    i2c_start();
    wr(8'h54, "rr_addr2_ack");
    wr(8'h00, "rr_ptr2_ack");
    i2c_start();
    wr(8'h55, "rr_raddr_ack");
    for (int i = 0; i < 3; i++) begin
      sda_m = 1'b1; hold(Q);
      scl_m = 1'b1; hold(Q);
      scl_m = 1'b0;
    end
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q/2);
    check_eq("rr_oe_before", sda_oe, 1'b1);
    RST = 1'b1;
    @(posedge clk); #1;
    check_eq("rr_oe_after", sda_oe, 1'b0);
    check_eq("rr_result", result, 16'h0000);
    check_eq("rr_done", done, 1'b0);
    check_eq("rr_busy", busy, 1'b0);
    @(negedge clk);
    RST = 1'b0;
    hold(Q/2);
    scl_m = 1'b0; hold(Q);
    i2c_stop();

    // Next transaction is addressed normally and sees cleared registers
    i2c_start();
    wr(8'h54, "post_addr_ack");
    wr(8'h00, "post_ptr_ack");
    i2c_start();
    wr(8'h55, "post_raddr_ack");
    rd(1'b0, 8'h00, "post_reg0");
    i2c_stop();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
